// File: rtl/mouse_cmd_pkg.sv
// Shared PS/2 mouse command bytes, sequencer state encoding and helper functions
// for the mouse reconfiguration sequencer.
package mouse_cmd_pkg;

  localparam logic [7:0] CmdDisableRpt = 8'hF5;
  localparam logic [7:0] CmdSetRate    = 8'hF3;
  localparam logic [7:0] CmdSetRes     = 8'hE8;
  localparam logic [7:0] CmdEnableRpt  = 8'hF4;
  localparam logic [7:0] RspAck        = 8'hFA;
  localparam logic [7:0] RspResend     = 8'hFE;
  localparam logic [7:0] RspError      = 8'hFC;

  localparam logic [2:0] LastCmdIdx = 3'd5;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StSend     = 4'd1,
    StWaitSent = 4'd2,
    StWaitAck  = 4'd3,
    StNext     = 4'd4,
    StDone     = 4'd5,
    StFail     = 4'd6
  } state_e;

  function automatic logic rate_valid(input logic [7:0] rate);
    return rate inside {8'd10, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200};
  endfunction

  // Entry idx of the six-byte configuration command list.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [7:0] rate,
                                          input logic [1:0] res);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CmdDisableRpt;
      3'd1:    b = CmdSetRate;
      3'd2:    b = rate;
      3'd3:    b = CmdSetRes;
      3'd4:    b = {6'b000000, res};
      default: b = CmdEnableRpt;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mouse_config_sequencer_if.sv
// Request/status and PS/2 transmitter/receiver control signals of the
// configuration sequencer; master is the sequencer side.
interface mouse_config_sequencer_if;
  logic       cfg_req;
  logic [7:0] cfg_sample_rate;
  logic [1:0] cfg_resolution;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_error;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;
  logic       read_enable;
  logic [7:0] byte_read;
  logic [1:0] byte_error_code;
  logic       byte_ready;
  logic [3:0] curr_state;

  modport master (
    input  cfg_req, cfg_sample_rate, cfg_resolution, byte_sent, byte_read, byte_error_code,
           byte_ready,
    output cfg_busy, cfg_done, cfg_error, send_byte, byte_to_send, read_enable, curr_state
  );

  modport slave (
    output cfg_req, cfg_sample_rate, cfg_resolution, byte_sent, byte_read, byte_error_code,
           byte_ready,
    input  cfg_busy, cfg_done, cfg_error, send_byte, byte_to_send, read_enable, curr_state
  );
endinterface

// File: rtl/ps2_timeout_timer.sv
// Per-byte watchdog: synchronous clear, counts while enabled, saturates at the
// terminal count and flags expiry while enabled.
module ps2_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 22) ? $clog2(TIMEOUT_CYCLES) : 22;
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != TermCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == TermCnt);

endmodule

// File: rtl/mouse_config_sequencer.sv
// Sends Disable Reporting, Set Sample Rate, Set Resolution, Enable Reporting to a
// PS/2 mouse, checking each byte for an ack with bounded retries and a timeout.
module mouse_config_sequencer
  import mouse_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input logic                     clk_i,
  input logic                     rst_i,
  mouse_config_sequencer_if.master bus_io
);

  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRIES);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        rate_q, rate_d;
  logic [1:0]        res_q, res_d;
  logic              send_q, send_d;
  logic [7:0]        byte_q, byte_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic do_retry;
  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;

  assign tmr_clear  = (state_q == StSend);
  assign tmr_enable = (state_q == StWaitSent) || (state_q == StWaitAck);

  ps2_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    rate_d   = rate_q;
    res_d    = res_q;
    do_retry = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.cfg_req) begin
          if (!rate_valid(bus_io.cfg_sample_rate)) begin
            state_d = StFail;
          end else begin
            rate_d  = bus_io.cfg_sample_rate;
            res_d   = bus_io.cfg_resolution;
            idx_d   = 3'd0;
            retry_d = '0;
            state_d = StSend;
          end
        end
      end
      StSend: state_d = StWaitSent;
      StWaitSent: begin
        if (bus_io.byte_sent) begin
          state_d = StWaitAck;
        end else if (tmr_expired) begin
          do_retry = 1'b1;
        end
      end
      StWaitAck: begin
        // Non-ack bytes before the first ack are leftover stream packets, not replies.
        if (bus_io.byte_ready) begin
          if ((bus_io.byte_error_code != 2'b00) || (bus_io.byte_read == RspError) ||
              (bus_io.byte_read == RspResend)) begin
            do_retry = 1'b1;
          end else if (bus_io.byte_read == RspAck) begin
            state_d = StNext;
          end else if (idx_q != 3'd0) begin
            do_retry = 1'b1;
          end
        end else if (tmr_expired) begin
          do_retry = 1'b1;
        end
      end
      StNext: begin
        if (idx_q == LastCmdIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          retry_d = '0;
          state_d = StSend;
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (do_retry) begin
      if (retry_q == MaxRetry) begin
        state_d = StFail;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = StSend;
      end
    end

    send_d  = (state_d == StSend);
    byte_d  = send_d ? cmd_byte(idx_d, rate_d, res_d) : byte_q;
    rd_en_d = (state_d == StWaitSent) || (state_d == StWaitAck);
    busy_d  = state_d inside {StSend, StWaitSent, StWaitAck, StNext};
    done_d  = (state_d == StDone);
    // Error pulse follows the FAIL state by one cycle, giving a two-cycle invalid-rate latency.
    err_d   = (state_q == StFail);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      retry_q <= '0;
      rate_q  <= 8'h00;
      res_q   <= 2'b00;
      send_q  <= 1'b0;
      byte_q  <= 8'h00;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      rate_q  <= rate_d;
      res_q   <= res_d;
      send_q  <= send_d;
      byte_q  <= byte_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.cfg_busy     = busy_q;
  assign bus_io.cfg_done     = done_q;
  assign bus_io.cfg_error    = err_q;
  assign bus_io.send_byte    = send_q;
  assign bus_io.byte_to_send = byte_q;
  assign bus_io.read_enable  = rd_en_q;
  assign bus_io.curr_state   = state_q;

endmodule

// File: tb/tb_mouse_config_sequencer.sv
// Bench for mouse_config_sequencer: table of request vectors, directed corner
// sequences and randomized mouse responses against a response-level model.
module tb_mouse_config_sequencer;

  localparam int unsigned To = 100;
  localparam int unsigned Mr = 3;
  localparam int Bound = 400;

  localparam int KAck = 0;
  localparam int KResend = 1;
  localparam int KNak = 2;
  localparam int KErrCode = 3;
  localparam int KNoise = 4;
  localparam int KTimeout = 5;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] sent_log[$];
  int         script_q[$];
  bit         rnd_mode;

  mouse_config_sequencer_if bus ();

  mouse_config_sequencer #(
    .TIMEOUT_CYCLES(To),
    .MAX_RETRIES   (Mr)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  typedef struct {
    logic [7:0]      rate;
    logic [1:0]      res;
    bit              valid;
    logic [0:5][7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reply(input logic [7:0] b, input logic [1:0] e);
    bus.byte_ready      = 1'b1;
    bus.byte_read       = b;
    bus.byte_error_code = e;
    @(negedge clk);
    bus.byte_ready      = 1'b0;
    bus.byte_error_code = 2'b00;
  endtask

  task automatic wait_send(output bit got, output logic [7:0] b, output int at);
    got = 1'b0;
    b   = 8'h00;
    at  = 0;
    for (int i = 0; i < Bound && !got; i++) begin
      if (bus.send_byte === 1'b1) begin
        got = 1'b1;
        b   = bus.byte_to_send;
        at  = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  function automatic int next_kind();
    int r;
    if (script_q.size() > 0) return script_q.pop_front();
    if (!rnd_mode) return KAck;
    r = int'($urandom_range(0, 99));
    if (r < 60) return KAck;
    if (r < 70) return KResend;
    if (r < 78) return KNak;
    if (r < 86) return KErrCode;
    if (r < 96) return KNoise;
    return KTimeout;
  endfunction

  // Model: walk the command list; ack advances, anything else retries up to Mr times.
  task automatic run_seq(input logic [7:0] rate, input logic [1:0] res, output int outcome);
    logic [7:0] cmds[6];
    logic [7:0] b;
    int idx, retry, kind, last_at, at;
    bit got, acked, fin, seen;
    cmds[0] = 8'hF5; cmds[1] = 8'hF3; cmds[2] = rate;
    cmds[3] = 8'hE8; cmds[4] = {6'b000000, res}; cmds[5] = 8'hF4;
    sent_log.delete();
    outcome = 0; idx = 0; retry = 0; fin = 1'b0; kind = KAck; last_at = 0;
    @(negedge clk);
    bus.cfg_req = 1'b1; bus.cfg_sample_rate = rate; bus.cfg_resolution = res;
    @(negedge clk);
    bus.cfg_req = 1'b0;
    check("busy_after_req", bus.cfg_busy, 1);
    check("send_after_req", bus.send_byte, 1);
    while (!fin) begin
      wait_send(got, b, at);
      if (!got) begin
        n_chk++; n_fail++;
        $display("FAIL send_wait: got no SEND_BYTE, expected byte %0h (cycle %0d)", cmds[idx], cyc);
        return;
      end
      check("send_byte_value", b, cmds[idx]);
      check("rd_en_in_send", bus.read_enable, 0);
      if (kind == KTimeout) check("timeout_gap", at - last_at, To + 1);
      sent_log.push_back(b);
      last_at = at;
      kind = next_kind();
      @(negedge clk);
      check("rd_en_wait_sent", bus.read_enable, 1);
      bus.byte_sent = 1'b1;
      @(negedge clk);
      bus.byte_sent = 1'b0;
      acked = (kind == KAck) || (kind == KNoise && idx == 0);
      case (kind)
        KAck:     reply(8'hFA, 2'b00);
        KResend:  reply(8'hFE, 2'b00);
        KNak:     reply(8'hFC, 2'b00);
        KErrCode: reply(8'hFA, 2'b10);
        KNoise: begin
          if (idx == 0) begin
            reply(8'h08, 2'b00); reply(8'h01, 2'b00); reply(8'hFF, 2'b00); reply(8'hFA, 2'b00);
          end else begin
            reply(8'h33, 2'b00);
          end
        end
        default: ;
      endcase
      if (acked && idx == 5) begin
        check("done_lag1", bus.cfg_done, 0);
        check("busy_lag1", bus.cfg_busy, 1);
        @(negedge clk);
        check("done_lag2", bus.cfg_done, 1);
        check("busy_lag2", bus.cfg_busy, 0);
        check("byte_hold", bus.byte_to_send, cmds[5]);
        @(negedge clk);
        check("done_pulse_end", bus.cfg_done, 0);
        check("no_err_on_done", bus.cfg_error, 0);
        outcome = 1; fin = 1'b1;
      end else if (acked) begin
        idx++; retry = 0;
      end else if (retry == Mr) begin
        if (kind != KTimeout) begin
          check("err_lag1", bus.cfg_error, 0);
          check("fail_state", bus.curr_state, 6);
          @(negedge clk);
        end else begin
          seen = 1'b0;
          for (int i = 0; i < Bound && !seen; i++) begin
            if (bus.cfg_error === 1'b1) seen = 1'b1;
            else @(negedge clk);
          end
        end
        check("err_pulse", bus.cfg_error, 1);
        check("busy_on_err", bus.cfg_busy, 0);
        @(negedge clk);
        check("err_pulse_end", bus.cfg_error, 0);
        outcome = 2; fin = 1'b1;
      end else begin
        retry++;
      end
    end
    @(negedge clk);
  endtask

  task automatic req_invalid(input logic [7:0] rate);
    @(negedge clk);
    bus.cfg_req = 1'b1; bus.cfg_sample_rate = rate; bus.cfg_resolution = 2'd1;
    @(negedge clk);
    bus.cfg_req = 1'b0;
    check("inv_send_k1", bus.send_byte, 0);
    check("inv_busy_k1", bus.cfg_busy, 0);
    check("inv_err_k1", bus.cfg_error, 0);
    @(negedge clk);
    check("inv_err_k2", bus.cfg_error, 1);
    check("inv_send_k2", bus.send_byte, 0);
    @(negedge clk);
    check("inv_err_k3", bus.cfg_error, 0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [7:0] valid_rates[7];
    int outcome, n_f3, n_f4, spurious;
    bit got;
    logic [7:0] b;
    int at;

    valid_rates = '{8'd10, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200};
    vecs[0] = '{rate: 8'd100, res: 2'd2, valid: 1'b1, exp: {8'hF5, 8'hF3, 8'h64, 8'hE8, 8'h02, 8'hF4}};
    vecs[1] = '{rate: 8'd10,  res: 2'd0, valid: 1'b1, exp: {8'hF5, 8'hF3, 8'h0A, 8'hE8, 8'h00, 8'hF4}};
    vecs[2] = '{rate: 8'd200, res: 2'd3, valid: 1'b1, exp: {8'hF5, 8'hF3, 8'hC8, 8'hE8, 8'h03, 8'hF4}};
    vecs[3] = '{rate: 8'd40,  res: 2'd1, valid: 1'b1, exp: {8'hF5, 8'hF3, 8'h28, 8'hE8, 8'h01, 8'hF4}};
    vecs[4] = '{rate: 8'd50,  res: 2'd1, valid: 1'b0, exp: '0};
    vecs[5] = '{rate: 8'd0,   res: 2'd0, valid: 1'b0, exp: '0};
    vecs[6] = '{rate: 8'd255, res: 2'd3, valid: 1'b0, exp: '0};
    vecs[7] = '{rate: 8'd101, res: 2'd2, valid: 1'b0, exp: '0};

    rst = 1'b1; rnd_mode = 1'b0;
    bus.cfg_req = 1'b0; bus.cfg_sample_rate = 8'h00; bus.cfg_resolution = 2'b00;
    bus.byte_sent = 1'b0; bus.byte_read = 8'h00; bus.byte_error_code = 2'b00;
    bus.byte_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_send", bus.send_byte, 0);
    check("rst_byte", bus.byte_to_send, 8'h00);
    check("rst_rd_en", bus.read_enable, 0);
    check("rst_busy", bus.cfg_busy, 0);
    check("rst_done", bus.cfg_done, 0);
    check("rst_err", bus.cfg_error, 0);
    check("rst_state", bus.curr_state, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].valid) begin
        run_seq(vecs[i].rate, vecs[i].res, outcome);
        check("vec_outcome", outcome, 1);
        check("vec_len", sent_log.size(), 6);
        for (int j = 0; j < 6 && j < sent_log.size(); j++) check("vec_byte", sent_log[j], vecs[i].exp[j]);
      end else begin
        req_invalid(vecs[i].rate);
      end
    end

    script_q = '{KNoise};
    run_seq(8'd100, 2'd2, outcome);
    check("noise_outcome", outcome, 1);
    check("noise_len", sent_log.size(), 6);
    check("noise_second", sent_log[1], 8'hF3);

    script_q = '{KAck, KAck, KAck, KResend};
    run_seq(8'd100, 2'd2, outcome);
    check("resend_outcome", outcome, 1);
    check("resend_len", sent_log.size(), 7);
    check("resend_e8_a", sent_log[3], 8'hE8);
    check("resend_e8_b", sent_log[4], 8'hE8);

    script_q = '{KAck, KNak, KNak, KNak, KNak};
    run_seq(8'd100, 2'd2, outcome);
    n_f3 = 0; n_f4 = 0;
    foreach (sent_log[i]) begin
      if (sent_log[i] == 8'hF3) n_f3++;
      if (sent_log[i] == 8'hF4) n_f4++;
    end
    check("abort_outcome", outcome, 2);
    check("abort_f3_count", n_f3, 4);
    check("abort_no_f4", n_f4, 0);

    script_q = '{KTimeout};
    run_seq(8'd60, 2'd1, outcome);
    check("timeout_outcome", outcome, 1);
    check("timeout_resent_f5", sent_log[1], 8'hF5);

    // Reset while waiting for the F5 ack.
    @(negedge clk);
    bus.cfg_req = 1'b1; bus.cfg_sample_rate = 8'd80; bus.cfg_resolution = 2'd0;
    @(negedge clk);
    bus.cfg_req = 1'b0;
    wait_send(got, b, at);
    check("mid_rst_send_seen", got, 1);
    @(negedge clk); bus.byte_sent = 1'b1;
    @(negedge clk); bus.byte_sent = 1'b0;
    check("mid_rst_wait_ack", bus.curr_state, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_send", bus.send_byte, 0);
    check("mid_rst_byte", bus.byte_to_send, 8'h00);
    check("mid_rst_rd_en", bus.read_enable, 0);
    check("mid_rst_busy", bus.cfg_busy, 0);
    check("mid_rst_done", bus.cfg_done, 0);
    check("mid_rst_err", bus.cfg_error, 0);
    check("mid_rst_state", bus.curr_state, 0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.cfg_done !== 1'b0 || bus.cfg_error !== 1'b0 || bus.send_byte !== 1'b0) spurious++;
    end
    check("post_rst_quiet", spurious, 0);

    rnd_mode = 1'b1;
    for (int i = 0; i < 25; i++) begin
      run_seq(valid_rates[$urandom_range(0, 6)], 2'($urandom_range(0, 3)), outcome);
      check("rnd_outcome", (outcome == 1) || (outcome == 2), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_config_sequencer.md
# mouse_config_sequencer

Sequences a PS/2 mouse reconfiguration after the master state machine has completed initialisation. On request, it sends Disable Reporting, Set Sample Rate, Set Resolution and Enable Reporting, and checks each byte for an acknowledge. The block drives the PS/2 transmitter/receiver control port while active; the top level muxes that port to it whenever CFG_BUSY is high. It handles resend requests, error bytes, timeouts and bounded retries.

## Interface
- TIMEOUT_CYCLES, 2500000, cycles allowed per byte from send to ack (50 ms at 50 MHz)
- MAX_RETRIES, 3, maximum retries per byte before abort
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- CFG_REQ  in  1  start request, sampled only in IDLE
- CFG_SAMPLE_RATE  in  8  samples/s, latched on accepted request
- CFG_RESOLUTION  in  2  resolution code 0–3, latched on accepted request
- CFG_BUSY  out  1  sequence in progress (owns transmitter/receiver port)
- CFG_DONE  out  1  one-cycle pulse on success
- CFG_ERROR  out  1  one-cycle pulse on abort or invalid rate
- SEND_BYTE  out  1  one-cycle transmit strobe
- BYTE_TO_SEND  out  8  byte for transmitter
- BYTE_SENT  in  1  transmitter completion pulse
- READ_ENABLE  out  1  receiver enable
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  receiver error, 00 = clean
- BYTE_READY  in  1  receiver byte-valid pulse
- CURR_STATE  out  4  state register, for debug

## Operation
- Command list (index 0–5): F5, F3, rate, E8, {6'b0,res}, F4. Each entry expects ack FA.
- States and encoding:
  - IDLE=0, SEND=1, WAIT_SENT=2, WAIT_ACK=3, NEXT=4, DONE=5, FAIL=6.
- IDLE: on CFG_REQ=1:
  - Rate not in {10,20,40,60,80,100,200}: go to FAIL. No byte is sent.
  - Otherwise: latch rate and res, index=0, retry=0, go to SEND.
- SEND: SEND_BYTE=1 for one cycle, BYTE_TO_SEND=list[index], clear timeout counter, go to WAIT_SENT.
- WAIT_SENT: on BYTE_SENT, go to WAIT_ACK.
- WAIT_ACK, on BYTE_READY:
  - Error code ≠00 or byte=FC: retry.
  - Byte=FE (resend): retry.
  - Byte=FA: go to NEXT.
  - Any other byte with index=0: discard, stay (in-flight stream packet bytes).
  - Any other byte with index>0: retry.
- Retry: if retry==MAX_RETRIES go to FAIL; else retry+1, go to SEND with the same index.
- Timeout: counter reaching TIMEOUT_CYCLES-1 in WAIT_SENT/WAIT_ACK triggers a retry.
- NEXT: if index==5 go to DONE; else index+1, retry=0, go to SEND.
- DONE: CFG_DONE=1, then IDLE. FAIL: CFG_ERROR=1, then IDLE.
- CFG_BUSY=1 in states 1–4 only.
- READ_ENABLE=1 in WAIT_SENT and WAIT_ACK.
- Counter 22 bits minimum, saturating. Retry counter wide enough for MAX_RETRIES.

## Timing
- All outputs registered.
- Reset values: SEND_BYTE 0, BYTE_TO_SEND 00, READ_ENABLE 0, CFG_BUSY 0, CFG_DONE 0, CFG_ERROR 0, CURR_STATE 0. Latched rate/res 00, counters 0.
- Latency:
  - CFG_REQ high at edge k: CFG_BUSY and SEND_BYTE high in cycle k+1.
  - Invalid rate: CFG_ERROR high in cycle k+2.
- Final FA at edge m: CFG_DONE high in cycle m+2; CFG_BUSY low from cycle m+2.
- BYTE_TO_SEND holds its value until the next SEND.
- BYTE_READY and timeout in the same cycle: BYTE_READY takes priority.
- BYTE_READY during WAIT_SENT is ignored.
- CFG_REQ while busy is ignored; no queueing.
- RESET mid-sequence: immediate return to IDLE, with no DONE or ERROR pulse.

## Structure
- Package mouse_cmd_pkg holds:
  - command constants (F5, F3, E8, F4, FA, FE, FC);
  - state encoding;
  - valid-rate check function.
- One sub-module, ps2_timeout_timer: clear input, enable input, terminal-count output, parameter TIMEOUT_CYCLES.

## Test plan
- Nominal: req rate=100, res=2, clean FA after each byte. Required: bytes F5,F3,64,E8,02,F4 in order, then CFG_DONE one cycle.
- Stream noise: before the F5 ack, feed bytes 08,01,FF, then FA. Required: no retry; the next byte sent is F3.
- Resend: FE after the E8 byte, then FA. Required: E8 re-sent once, sequence completes.
- Abort: FC after F3 four times with MAX_RETRIES=3. Required: F3 sent 4 times, CFG_ERROR pulse, F4 never sent.
- Invalid rate: req rate=50. Required: no SEND_BYTE, CFG_ERROR at k+2.
- Timeout and reset: withhold the ack (TIMEOUT_CYCLES=100). Required: F5 re-sent after 100 cycles. Then assert RESET mid-WAIT_ACK. Required: all outputs return to reset values the same cycle.
